openmips_run_ctrl: RTL

Parametrised reset sequencer and run-cycle monitor for the OpenMIPS minimal SoPC. It holds one or more core reset domains in reset for a programmable number of cycles and releases them in a staggered order. It then counts executed cycles and ends the run on a cycle limit or an external halt request. It sits between the board clock/reset and the `rst` inputs of `openmips_min_sopc` instances, replacing fixed delay-based reset and stop timing.

---
 rtl/openmips_run_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/openmips_run_ctrl.sv
// ---------------------------------------------------------------------------
// OpenMIPS run controller: reset sequencer and run-cycle monitor
//
// Holds NUM_CH core reset domains in reset for RST_CYCLES cycles after a
// start request. It then releases the channels in ascending index order,
// one every STAGGER cycles. Once the last channel is free it counts RUN
// cycles. The run ends on RUN_CYCLES (timeout) or on an external halt
// request. Afterwards it parks in DONE with all cores held in reset until
// the next start.
//
// Parameters
//   RST_CYCLES  cycles all channels are held after start (>= 1)
//   RUN_CYCLES  run length in cycles, 0 = unlimited (halt only)
//   NUM_CH      number of reset channels (>= 1)
//   STAGGER     cycles between successive channel releases, 0 = together
//   CNT_W       width of the run-cycle counter
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-low block reset
//   start_i      start / restart request (honoured in IDLE and DONE)
//   halt_req_i   end-of-run request (honoured in RUN)
//   cpu_rst_o    per-channel core reset, active high
//   running_o    high while in RUN
//   done_o       high while in DONE
//   timeout_o    in DONE: 1 = ended on RUN_CYCLES, 0 = ended on halt
//   cycle_cnt_o  number of RUN cycles executed
// ---------------------------------------------------------------------------
module openmips_run_ctrl #(
  parameter int RST_CYCLES = 6,
  parameter int RUN_CYCLES = 50,
  parameter int NUM_CH     = 2,
  parameter int STAGGER    = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              halt_req_i,
  output logic [NUM_CH-1:0] cpu_rst_o,
  output logic              running_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RELEASE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Release step at which the highest-index channel is freed.
  localparam int LAST_STEP = (NUM_CH - 1) * STAGGER;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Count value seen on the edge that completes a limited run.
  localparam logic [CNT_W-1:0] RUN_LAST = (RUN_CYCLES == 0) ? '0 : CNT_W'(RUN_CYCLES - 1);

  state_t            r_state;
  logic [31:0]       r_dly;
  logic [NUM_CH-1:0] r_cpuRst;
  logic              r_running;
  logic              r_done;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cnt;

  logic [31:0]       w_step;
  logic [NUM_CH-1:0] w_relMask;
  logic              w_lastStep;
  logic [CNT_W-1:0]  w_cntInc;

  // Release-step decode. The final RESET edge is release step 0. Each
  // RELEASE edge then applies step r_dly, so channel k is free once
  // k*STAGGER <= step. w_relMask is the reset pattern for that step.
  always_comb begin
    w_step     = (r_state == ST_RELEASE) ? r_dly : 32'd0;
    w_relMask  = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      w_relMask[k] = (32'(k * STAGGER) > w_step);
    end
    w_lastStep = (w_step == 32'(LAST_STEP));
    // Saturate rather than wrap; only reachable in unlimited runs.
    w_cntInc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_dly     <= 32'd0;
      r_cpuRst  <= '1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cpuRst <= '1;
          if (start_i) begin
            r_state   <= ST_RESET;
            r_dly     <= 32'd0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
          end
        end

        ST_RESET: begin
          if (r_dly == 32'(RST_CYCLES - 1)) begin
            // Hold time is over: this edge is release step 0.
            r_cpuRst <= w_relMask;
            if (w_lastStep) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end else begin
              r_state <= ST_RELEASE;
              r_dly   <= 32'd1;
            end
          end else begin
            r_dly <= r_dly + 32'd1;
          end
        end

        ST_RELEASE: begin
          // ANDing with the current value keeps freed channels free.
          r_cpuRst <= r_cpuRst & w_relMask;
          if (w_lastStep) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else begin
            r_dly <= r_dly + 32'd1;
          end
        end

        ST_RUN: begin
          r_cnt <= w_cntInc;
          // Halt wins over a coinciding limit; the count still advances.
          if (halt_req_i) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b0;
            r_cpuRst  <= '1;
          end else if ((RUN_CYCLES != 0) && (r_cnt == RUN_LAST)) begin
            r_state   <= ST_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_cpuRst  <= '1;
          end
        end

        ST_DONE: begin
          r_cpuRst <= '1;
          if (start_i) begin
            r_state   <= ST_RESET;
            r_dly     <= 32'd0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_dly     <= 32'd0;
          r_cpuRst  <= '1;
          r_running <= 1'b0;
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign cpu_rst_o   = r_cpuRst;
  assign running_o   = r_running;
  assign done_o      = r_done;
  assign timeout_o   = r_timeout;
  assign cycle_cnt_o = r_cnt;

endmodule
